// File: rtl/ahbl_slave_mem_model.sv
// AHB-Lite responder over a word-addressed memory with wait states, two-cycle ERROR
// responses and, when AHBL_SLAVE_MEM_EXCL_EN is defined, a single-reservation exclusive monitor.
module ahbl_slave_mem_model #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    output logic              ahbls_hexokay,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic              ahbls_hexcl,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,
    input  logic [3:0]        wait_cycles
);

    localparam int NB    = W_DATA / 8;
    localparam int LSB_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [W_ADDR:0] LIMIT = (W_ADDR + 1)'(DEPTH * NB);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LSB_W-1:0]   lo_q, lo_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;
    logic [W_DATA-1:0]  mem_q [DEPTH];

    logic               hready_resp_s;
    logic               accept_s;
    logic               in_range_s;
    logic               last_s;
    logic               commit_s;
    logic               hexokay_s;
    logic [NB-1:0]      wmask_s;
    logic               unused_s;

    // Byte lanes touched by a transfer of the given size at the given low address bits
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [LSB_W-1:0] lo);
        logic [NB-1:0] m;
        int nbytes;
        int base;
        m = '0;
        nbytes = 32'sd1 << size;
        if (nbytes >= NB) begin
            m = '1;
        end else begin
            base = int'(lo) & ~(nbytes - 32'sd1);
            for (int b = 0; b < NB; b++) begin
                if ((b >= base) && (b < base + nbytes)) m[b] = 1'b1;
                else m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    assign hready_resp_s = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    assign accept_s      = ahbls_hready && ahbls_htrans[1] && hready_resp_s;
    assign in_range_s    = ({1'b0, ahbls_haddr} < LIMIT);
    assign last_s        = (state_q == ST_LAST);
    assign wmask_s       = lane_mask(size_q, lo_q);

`ifdef AHBL_SLAVE_MEM_EXCL_EN
    logic               excl_q, excl_d;
    logic               resv_valid_q;
    logic [IDX_W-1:0]   resv_idx_q;
    logic               resv_hit_s;

    assign resv_hit_s = resv_valid_q && (resv_idx_q == idx_q);
    assign hexokay_s  = last_s && excl_q && (!write_q || resv_hit_s);
    assign commit_s   = last_s && write_q && (!excl_q || resv_hit_s) && !rst;
    assign unused_s   = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0]};

    // Reservation: set by exclusive reads, dropped by any exclusive write or a plain write to it
    always_ff @(posedge clk) begin
        if (rst) begin
            resv_valid_q <= 1'b0;
            resv_idx_q   <= '0;
        end else if (last_s && excl_q && !write_q) begin
            resv_valid_q <= 1'b1;
            resv_idx_q   <= idx_q;
        end else if (last_s && write_q && (excl_q || (resv_idx_q == idx_q))) begin
            resv_valid_q <= 1'b0;
        end else begin
            resv_valid_q <= resv_valid_q;
        end
    end
`else
    assign hexokay_s = 1'b0;
    assign commit_s  = last_s && write_q && !rst;
    assign unused_s  = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0], ahbls_hexcl};
`endif

    // Next-state and data-phase capture; only IDLE/LAST/ERR2 can take a new address phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
`ifdef AHBL_SLAVE_MEM_EXCL_EN
        excl_d  = excl_q;
`endif
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_LAST;
                else state_d = ST_WAIT;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (accept_s) begin
                    idx_d   = ahbls_haddr[LSB_W +: IDX_W];
                    lo_d    = ahbls_haddr[LSB_W-1:0];
                    size_d  = ahbls_hsize;
                    write_d = ahbls_hwrite;
                    cnt_d   = wait_cycles;
`ifdef AHBL_SLAVE_MEM_EXCL_EN
                    excl_d  = ahbls_hexcl;
`endif
                    if (!in_range_s) state_d = ST_ERR1;
                    else if (wait_cycles == 4'd0) state_d = ST_LAST;
                    else state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data-phase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lo_q    <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
`ifdef AHBL_SLAVE_MEM_EXCL_EN
            excl_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            write_q <= write_d;
`ifdef AHBL_SLAVE_MEM_EXCL_EN
            excl_q  <= excl_d;
`endif
        end
    end

    // Memory array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask_s[b]) mem_q[idx_q][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
            end
        end
    end

    assign ahbls_hready_resp = hready_resp_s;
    assign ahbls_hresp       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign ahbls_hexokay     = hexokay_s;
    assign ahbls_hrdata      = last_s ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahbl_slave_mem_model.sv
// Self-checking bench for ahbl_slave_mem_model: directed scenarios plus randomized
// transfers compared against a word-array reference model of the memory and reservation.
module tb_ahbl_slave_mem_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic        ahbls_hexokay;
    logic [31:0] ahbls_haddr;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize;
    logic [2:0]  ahbls_hburst;
    logic [3:0]  ahbls_hprot;
    logic        ahbls_hmastlock;
    logic        ahbls_hexcl;
    logic [31:0] ahbls_hwdata;
    logic [31:0] ahbls_hrdata;
    logic [3:0]  wait_cycles;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [0:63];
    bit          rv;
    int          ri;
    logic [31:0] rd;

    always #5 clk = ~clk;

    assign ahbls_hready = ahbls_hready_resp;

    ahbl_slave_mem_model dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_hexokay     (ahbls_hexokay),
        .ahbls_haddr       (ahbls_haddr),
        .ahbls_hwrite      (ahbls_hwrite),
        .ahbls_htrans      (ahbls_htrans),
        .ahbls_hsize       (ahbls_hsize),
        .ahbls_hburst      (ahbls_hburst),
        .ahbls_hprot       (ahbls_hprot),
        .ahbls_hmastlock   (ahbls_hmastlock),
        .ahbls_hexcl       (ahbls_hexcl),
        .ahbls_hwdata      (ahbls_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .wait_cycles       (wait_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer: drive address phase, check every data-phase cycle, update model
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] sz,
                        input logic [31:0] wd, input int k, input bit ex,
                        input string tag, output logic [31:0] rdo);
        bit inr;
        int w;
        bit exok;
        bit commit;
        int nb;
        int st;
        inr = (addr < 32'd4096);
        w   = int'(addr >> 2) % 64;
        ahbls_haddr  = addr;
        ahbls_hwrite = wr;
        ahbls_hsize  = sz;
        ahbls_hexcl  = ex;
        wait_cycles  = 4'(k);
        ahbls_htrans = 2'b10;
        @(posedge clk); #1;
        ahbls_htrans = 2'b00;
        ahbls_hwdata = wr ? wd : $urandom();
        rdo = '0;
        if (!inr) begin
            @(negedge clk);
            chk({tag, "/err1_resp"}, ahbls_hresp, 32'd1);
            chk({tag, "/err1_rdy"}, ahbls_hready_resp, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "/err2_resp"}, ahbls_hresp, 32'd1);
            chk({tag, "/err2_rdy"}, ahbls_hready_resp, 32'd1);
            chk({tag, "/err2_exok"}, ahbls_hexokay, 32'd0);
            @(posedge clk); #1;
        end else begin
            exok   = 1'b0;
            commit = wr;
`ifdef AHBL_SLAVE_MEM_EXCL_EN
            if (ex && !wr) exok = 1'b1;
            if (ex && wr) begin
                exok   = rv && (ri == w);
                commit = exok;
            end
`endif
            for (int i = 0; i < k; i++) begin
                @(negedge clk);
                chk({tag, "/wait_rdy"}, ahbls_hready_resp, 32'd0);
                chk({tag, "/wait_resp"}, ahbls_hresp, 32'd0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk({tag, "/last_rdy"}, ahbls_hready_resp, 32'd1);
            chk({tag, "/last_resp"}, ahbls_hresp, 32'd0);
            chk({tag, "/last_exok"}, ahbls_hexokay, 32'(exok));
            rdo = ahbls_hrdata;
            if (!wr) chk({tag, "/rdata"}, ahbls_hrdata, ref_mem[w]);
            @(posedge clk); #1;
            if (commit) begin
                nb = 1 << sz;
                st = int'(addr % 32'd4);
                for (int b = st; b < st + nb; b++) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
`ifdef AHBL_SLAVE_MEM_EXCL_EN
            if (ex && !wr) begin
                rv = 1'b1;
                ri = w;
            end else if (ex && wr) begin
                rv = 1'b0;
            end else if (wr && (ri == w)) begin
                rv = 1'b0;
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int          word;
        int          sz;
        int          k;
        rst = 1'b1;
        ahbls_haddr = 32'd0; ahbls_hwrite = 1'b0; ahbls_htrans = 2'b00; ahbls_hsize = 3'd0;
        ahbls_hburst = 3'd0; ahbls_hprot = 4'd0; ahbls_hmastlock = 1'b0; ahbls_hexcl = 1'b0;
        ahbls_hwdata = 32'd0; wait_cycles = 4'd0;
        rv = 1'b0; ri = -1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/rdy", ahbls_hready_resp, 32'd1);
        chk("reset/resp", ahbls_hresp, 32'd0);
        chk("reset/exok", ahbls_hexokay, 32'd0);
        chk("reset/rdata", ahbls_hrdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int w = 0; w < 64; w++) xfer(32'(w * 4), 1'b1, 3'd2, $urandom(), 0, 1'b0, "fill", rd);

        // Zero-wait pipelined write then read of 0x10
        ahbls_haddr = 32'h10; ahbls_hwrite = 1'b1; ahbls_hsize = 3'd2; ahbls_hexcl = 1'b0;
        wait_cycles = 4'd0; ahbls_htrans = 2'b10;
        @(posedge clk); #1;
        ahbls_hwdata = 32'hdeadbeef; ahbls_hwrite = 1'b0;
        @(negedge clk);
        chk("pipe/wr_last_rdy", ahbls_hready_resp, 32'd1);
        @(posedge clk); #1;
        ahbls_htrans = 2'b00;
        @(negedge clk);
        chk("pipe/rd_last_rdy", ahbls_hready_resp, 32'd1);
        chk("pipe/rdata", ahbls_hrdata, 32'hdeadbeef);
        @(posedge clk); #1;
        ref_mem[4] = 32'hdeadbeef;
        if (ri == 4) rv = 1'b0;

        xfer(32'h20, 1'b0, 3'd2, 32'd0, 3, 1'b0, "wait3", rd);

        // Byte lane merge
        xfer(32'h40, 1'b1, 3'd2, 32'h11223344, 0, 1'b0, "lane_init", rd);
        xfer(32'h41, 1'b1, 3'd0, 32'haaaaaaaa, 1, 1'b0, "lane_byte", rd);
        xfer(32'h40, 1'b0, 3'd2, 32'd0, 0, 1'b0, "lane_rd", rd);
        chk("byte_lane", rd, 32'h1122aa44);

        // Out-of-range read and write; aliasing word must stay intact
        xfer(32'd4096, 1'b0, 3'd2, 32'd0, 5, 1'b0, "err_rd", rd);
        xfer(32'd4096 + 32'h10, 1'b1, 3'd2, 32'h5a5a5a5a, 2, 1'b0, "err_wr", rd);
        xfer(32'h10, 1'b0, 3'd2, 32'd0, 0, 1'b0, "err_chk", rd);
        chk("err_no_write", rd, 32'hdeadbeef);

        // BUSY gets a zero-wait OKAY
        ahbls_htrans = 2'b01;
        @(posedge clk); #1;
        ahbls_htrans = 2'b00;
        @(negedge clk);
        chk("busy/rdy", ahbls_hready_resp, 32'd1);
        chk("busy/resp", ahbls_hresp, 32'd0);
        @(posedge clk); #1;

        // Exclusive sequence
        xfer(32'h80, 1'b0, 3'd2, 32'd0, 0, 1'b1, "ex_rd1", rd);
        xfer(32'h80, 1'b1, 3'd2, 32'h0a0a0a0a, 1, 1'b1, "ex_wr1", rd);
        xfer(32'h80, 1'b1, 3'd2, 32'h0b0b0b0b, 0, 1'b1, "ex_wr2", rd);
        xfer(32'h80, 1'b0, 3'd2, 32'd0, 0, 1'b1, "ex_rd2", rd);
        xfer(32'h80, 1'b1, 3'd2, 32'h0c0c0c0c, 0, 1'b0, "ex_plain", rd);
        xfer(32'h80, 1'b1, 3'd2, 32'h0d0d0d0d, 2, 1'b1, "ex_wr3", rd);
        xfer(32'h80, 1'b0, 3'd2, 32'd0, 0, 1'b0, "ex_final", rd);
`ifdef AHBL_SLAVE_MEM_EXCL_EN
        chk("ex_final_word", rd, 32'h0c0c0c0c);
`else
        chk("ex_final_word", rd, 32'h0d0d0d0d);
`endif

        // Reset in the middle of a waited write
        ahbls_haddr = 32'h30; ahbls_hwrite = 1'b1; ahbls_hsize = 3'd2; ahbls_hexcl = 1'b0;
        wait_cycles = 4'd4; ahbls_htrans = 2'b10;
        @(posedge clk); #1;
        ahbls_htrans = 2'b00; ahbls_hwdata = 32'hcafef00d;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid/wait_rdy", ahbls_hready_resp, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid/rdy", ahbls_hready_resp, 32'd1);
        chk("rstmid/resp", ahbls_hresp, 32'd0);
        chk("rstmid/exok", ahbls_hexokay, 32'd0);
        chk("rstmid/rdata", ahbls_hrdata, 32'd0);
        @(posedge clk); #1;
        rv = 1'b0;
        xfer(32'h30, 1'b0, 3'd2, 32'd0, 0, 1'b0, "rstmid_chk", rd);

        // Randomized transfers against the reference model
        for (int n = 0; n < 120; n++) begin
            word = $urandom_range(0, 15);
            sz   = $urandom_range(0, 2);
            a    = 32'(word * 4) + (32'($urandom_range(0, 3)) & ~(32'(1 << sz) - 32'd1));
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? 32'hfffffffc : 32'd4096 + 32'($urandom_range(0, 1023) * 4);
            end
            k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            xfer(a, 1'($urandom_range(0, 1)), 3'(sz), $urandom(), k,
                 ($urandom_range(0, 3) == 0), "rand", rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
